wb_default_slave: RTL

- Parametrised WISHBONE default/terminator slave for the ao68000 system bus.
- Terminates cycles that hit configurable address windows with ACK, ERR or RTY after a programmable wait-state count.
- Returns RTY for ao68000 interrupt-acknowledge (CPU space) cycles.
- Runs a bus watchdog that ends any cycle left unanswered by all other slaves with ERR, and latches the first faulting access for software/debug.

---
 rtl/wb_term_pkg.sv | 19 +
 rtl/wb_term_addr_decoder.sv | 32 +++
 rtl/wb_default_slave.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_term_pkg.sv
// Shared constants and types for the WISHBONE default/terminator slave.
// Mode encodings match the per-window WIN_MODE parameter fields.
package wb_term_pkg;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_ACK = 2'b01;
    localparam logic [1:0] MODE_ERR = 2'b10;
    localparam logic [1:0] MODE_RTY = 2'b11;

    // ao68000 interrupt-acknowledge cycles drive word address bits [29:3] all ones
    localparam logic [26:0] CPU_SPACE_PREFIX = 27'h7FFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_term_addr_decoder.sv
// Combinational priority comparator over the configured address windows.
// The lowest-numbered enabled window that matches supplies the response mode.
module wb_term_addr_decoder #(
    parameter int                     NUM_WIN  = 4,
    parameter logic [32*NUM_WIN-1:0]  WIN_BASE = {NUM_WIN{32'h0}},
    parameter logic [32*NUM_WIN-1:0]  WIN_MASK = {NUM_WIN{32'h0}},
    parameter logic [2*NUM_WIN-1:0]   WIN_MODE = {NUM_WIN{2'b00}}
) (
    input  logic [29:0] i_adr,
    output logic        o_hit,
    output logic [1:0]  o_mode
);
    import wb_term_pkg::*;

    logic [31:0] w_byteAdr;

    assign w_byteAdr = {i_adr, 2'b00};

    // Scan from the top index down so the lowest matching window overwrites last
    always_comb begin
        o_hit  = 1'b0;
        o_mode = MODE_OFF;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((((w_byteAdr ^ WIN_BASE[32*i +: 32]) & WIN_MASK[32*i +: 32]) == 32'h0) &&
                (WIN_MODE[2*i +: 2] != MODE_OFF)) begin
                o_hit  = 1'b1;
                o_mode = WIN_MODE[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/wb_default_slave.sv
// WISHBONE default slave: terminates window hits and CPU-space cycles, and
// ends unanswered cycles with ERR via a watchdog, recording the first fault.
module wb_default_slave #(
    parameter int                     NUM_WIN       = 4,
    parameter logic [32*NUM_WIN-1:0]  WIN_BASE      = {NUM_WIN{32'h0}},
    parameter logic [32*NUM_WIN-1:0]  WIN_MASK      = {NUM_WIN{32'h0}},
    parameter logic [2*NUM_WIN-1:0]   WIN_MODE      = {NUM_WIN{2'b00}},
    parameter int                     WAIT_STATES   = 0,
    parameter int                     TIMEOUT       = 256,
    parameter int                     CPU_SPACE_RTY = 1,
    parameter logic [31:0]            READ_DATA     = 32'h0
) (
    input  logic        CLK_I,
    input  logic        reset_n,
    input  logic [29:0] ADR_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] slave_DAT_I,
    output logic [31:0] slave_DAT_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        RTY_O,
    input  logic        cpu_space_cycle,
    input  logic        other_resp,
    output logic        fault_valid,
    output logic [29:0] fault_addr,
    output logic        fault_we,
    output logic [3:0]  fault_sel,
    output logic        fault_overflow,
    input  logic        fault_clear
);
    import wb_term_pkg::*;

    localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    state_t            r_state, w_stateNext;
    logic [1:0]        r_mode, w_modeNext;
    logic [3:0]        r_waitCnt, w_waitNext;
    logic [WD_W-1:0]   r_wdCnt;
    logic [29:0]       r_prevAdr;
    logic              r_wdArmed, r_lockout;
    logic              r_ack, r_err, r_rty;
    logic              r_faultValid, r_faultWe, r_faultOverflow;
    logic [29:0]       r_faultAddr;
    logic [3:0]        r_faultSel;

    logic              w_req, w_cpuHit, w_winHitRaw, w_winHit, w_accept;
    logic              w_wdActive, w_wdSame, w_wdFire, w_respNext, w_errNext;
    logic [1:0]        w_winMode;
    logic              w_unused_datI;

    wb_term_addr_decoder #(
        .NUM_WIN  (NUM_WIN),
        .WIN_BASE (WIN_BASE),
        .WIN_MASK (WIN_MASK),
        .WIN_MODE (WIN_MODE)
    ) u_decoder (
        .i_adr  (ADR_I),
        .o_hit  (w_winHitRaw),
        .o_mode (w_winMode)
    );

    assign w_req    = CYC_I & STB_I;
    assign w_cpuHit = cpu_space_cycle & (ADR_I[29:3] == CPU_SPACE_PREFIX) & ~WE_I & (CPU_SPACE_RTY != 0);
    assign w_winHit = w_winHitRaw & ~cpu_space_cycle;
    assign w_accept = (r_state == ST_IDLE) & ~r_lockout & w_req & (w_winHit | w_cpuHit);

    // Watchdog only watches plain cycles nobody here claims; any CPU-space cycle is exempt
    assign w_wdActive = (r_state == ST_IDLE) & ~r_lockout & w_req & ~w_winHit & ~cpu_space_cycle & (TIMEOUT != 0);
    assign w_wdSame   = r_wdArmed & (ADR_I == r_prevAdr) & ~other_resp;
    assign w_wdFire   = w_wdActive & w_wdSame & (r_wdCnt == WD_MAX);

    always_comb begin
        w_stateNext = r_state;
        w_modeNext  = r_mode;
        w_waitNext  = r_waitCnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stateNext = ST_WAIT;
                    w_modeNext  = w_cpuHit ? MODE_RTY : w_winMode;
                    w_waitNext  = 4'(WAIT_STATES);
                end else if (w_wdFire) begin
                    w_stateNext = ST_RESP;
                    w_modeNext  = MODE_ERR;
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_stateNext = ST_IDLE;
                end else if (r_waitCnt == 4'd0) begin
                    w_stateNext = ST_RESP;
                end else begin
                    w_waitNext = r_waitCnt - 4'd1;
                end
            end
            ST_RESP: w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_respNext = (w_stateNext == ST_RESP);
    assign w_errNext  = w_respNext & (w_modeNext == MODE_ERR);

    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_OFF;
            r_waitCnt <= 4'd0;
            r_wdCnt   <= '0;
            r_prevAdr <= 30'd0;
            r_wdArmed <= 1'b0;
            r_lockout <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rty     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_mode    <= w_modeNext;
            r_waitCnt <= w_waitNext;
            r_wdCnt   <= (w_wdActive & w_wdSame) ? r_wdCnt + WD_W'(1) : '0;
            r_prevAdr <= ADR_I;
            r_wdArmed <= w_wdActive;
            r_lockout <= (r_state == ST_RESP);
            r_ack     <= w_respNext & (w_modeNext == MODE_ACK);
            r_err     <= w_errNext;
            r_rty     <= w_respNext & (w_modeNext == MODE_RTY);
        end
    end

    // A fault landing on the same edge as fault_clear starts a fresh record
    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            r_faultValid    <= 1'b0;
            r_faultOverflow <= 1'b0;
            r_faultAddr     <= 30'd0;
            r_faultWe       <= 1'b0;
            r_faultSel      <= 4'd0;
        end else if (w_errNext) begin
            if (!r_faultValid || fault_clear) begin
                r_faultValid    <= 1'b1;
                r_faultOverflow <= 1'b0;
                r_faultAddr     <= ADR_I;
                r_faultWe       <= WE_I;
                r_faultSel      <= SEL_I;
            end else begin
                r_faultOverflow <= 1'b1;
            end
        end else if (fault_clear) begin
            r_faultValid    <= 1'b0;
            r_faultOverflow <= 1'b0;
        end
    end

    assign w_unused_datI  = ^slave_DAT_I;
    assign slave_DAT_O    = READ_DATA;
    assign ACK_O          = r_ack;
    assign ERR_O          = r_err;
    assign RTY_O          = r_rty;
    assign fault_valid    = r_faultValid;
    assign fault_overflow = r_faultOverflow;
    assign fault_addr     = r_faultAddr;
    assign fault_we       = r_faultWe;
    assign fault_sel      = r_faultSel;

endmodule
